rr_arbiter_4ch: RTL and testbench

- Round-robin arbiter that shares one downstream resource among 4 requesters.
- Registered 2-bit winner index drives a 2-to-4 one-hot decode to produce the grant vector.
- Grants are held until the owner releases or a hold-timeout fires.
- Sits between four request sources and a single shared datapath slot, e.g. a bus or memory port.

---
 rtl/rr_arb_pkg.sv | 32 +++
 rtl/onehot_dec_2x4.sv | 11 +
 rtl/rr_arbiter_4ch.sv | 93 +++++++++
 tb/tb_rr_arbiter_4ch.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rr_arb_pkg.sv
// Shared types, sizes and rotating-priority scan for the 4-requester round-robin arbiter.
package rr_arb_pkg;

    localparam int NUM_REQ = 4;
    localparam int IDX_W   = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    // First requester with req set, scanning ptr, ptr+1, ... modulo NUM_REQ.
    function automatic logic [IDX_W-1:0] next_winner(
        input logic [IDX_W-1:0]   ptr,
        input logic [NUM_REQ-1:0] req
    );
        logic [IDX_W-1:0] win;
        logic [IDX_W-1:0] cand;
        logic             found;
        win   = ptr;
        found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = ptr + IDX_W'(i);
            if (!found && req[cand]) begin
                win   = cand;
                found = 1'b1;
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/onehot_dec_2x4.sv
// 2-to-4 one-hot decoder with enable; purely combinational, zero latency.
// No flow control: output all-zero whenever en is low.
module onehot_dec_2x4 (
    input  logic [1:0] idx,
    input  logic       en,
    output logic [3:0] onehot
);

    assign onehot = en ? (4'b0001 << idx) : 4'b0000;

endmodule

// File: rtl/rr_arbiter_4ch.sv
// Round-robin arbiter for 4 requesters, 1-cycle request-to-grant latency, grant held until release or MAX_HOLD timeout.
// Owner holds the slot while its req stays high; en_in only gates new grants, never revokes a running one.
module rr_arbiter_4ch
    import rr_arb_pkg::*;
#(
    parameter int MAX_HOLD = 8,
    parameter int HCNT_W   = $clog2(MAX_HOLD)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en_in,
    input  logic [NUM_REQ-1:0] req_in,
    output logic [NUM_REQ-1:0] gnt_out,
    output logic [IDX_W-1:0]   gnt_idx_out,
    output logic               gnt_valid_out,
    output logic               timeout_out
);

    arb_state_t        state;
    arb_state_t        state_nxt;
    logic [IDX_W-1:0]  gnt_idx;
    logic [IDX_W-1:0]  ptr;
    logic [IDX_W-1:0]  ptr_nxt;
    logic [IDX_W-1:0]  winner;
    logic [HCNT_W-1:0] hold_cnt;
    logic              timeout;
    logic              owner_req;
    logic              hold_exp;
    logic              rel;
    logic              timeout_evt;
    logic              grant_new;

    // The winner on a release edge uses the already-advanced pointer, so handover has no bubble.
    always_comb begin
        owner_req   = req_in[gnt_idx];
        hold_exp    = (hold_cnt == HCNT_W'(MAX_HOLD - 1));
        rel         = (state == GRANT) && (!owner_req || hold_exp);
        timeout_evt = (state == GRANT) && owner_req && hold_exp;
        ptr_nxt     = rel ? (gnt_idx + IDX_W'(1)) : ptr;
        winner      = next_winner(ptr_nxt, req_in);
        grant_new   = en_in && (|req_in) && ((state == IDLE) || rel);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant_new) state_nxt = GRANT;
            GRANT:   if (rel && !grant_new) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gnt_idx  <= '0;
            ptr      <= '0;
            hold_cnt <= '0;
            timeout  <= 1'b0;
        end else begin
            ptr     <= ptr_nxt;
            timeout <= timeout_evt;
            if (grant_new) begin
                gnt_idx  <= winner;
                hold_cnt <= '0;
            end else if (rel) begin
                hold_cnt <= '0;
            end else if (state == GRANT) begin
                hold_cnt <= hold_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        gnt_valid_out = (state == GRANT);
        gnt_idx_out   = gnt_idx;
        timeout_out   = timeout;
    end

    onehot_dec_2x4 u_gnt_dec (
        .idx    (gnt_idx),
        .en     (gnt_valid_out),
        .onehot (gnt_out)
    );

endmodule

// File: tb/tb_rr_arbiter_4ch.sv
// Directed bench for rr_arbiter_4ch: owner/pointer model checked every cycle plus literal expectations per scenario.
module tb_rr_arbiter_4ch;

    localparam int MAX_HOLD = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en_in = 1'b0;
    logic [3:0] req_in = 4'b0000;
    logic [3:0] gnt_out;
    logic [1:0] gnt_idx_out;
    logic       gnt_valid_out;
    logic       timeout_out;

    int total = 0;
    int bad   = 0;
    bit chk   = 1'b0;

    // Model: current owner (-1 when idle), rotation pointer, cycles the owner has been shown.
    int m_owner = -1;
    int m_ptr   = 0;
    int m_held  = 0;
    bit m_to    = 1'b0;

    rr_arbiter_4ch #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk           (clk),
        .rst           (rst),
        .en_in         (en_in),
        .req_in        (req_in),
        .gnt_out       (gnt_out),
        .gnt_idx_out   (gnt_idx_out),
        .gnt_valid_out (gnt_valid_out),
        .timeout_out   (timeout_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int first_from(input int p, input logic [3:0] r);
        for (int k = 0; k < 4; k++) begin
            if (r[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    always @(posedge clk) begin : model
        bit rel;
        int nptr;
        if (rst) begin
            m_owner = -1;
            m_ptr   = 0;
            m_held  = 0;
            m_to    = 1'b0;
        end else begin
            rel  = 1'b0;
            nptr = m_ptr;
            m_to = 1'b0;
            if (m_owner >= 0) begin
                m_held++;
                if (!req_in[m_owner]) begin
                    rel = 1'b1;
                end else if (m_held == MAX_HOLD) begin
                    rel  = 1'b1;
                    m_to = 1'b1;
                end
                if (rel) nptr = (m_owner + 1) % 4;
            end
            if (m_owner < 0 || rel) begin
                m_ptr = nptr;
                if (en_in && req_in != 4'b0000) begin
                    m_owner = first_from(nptr, req_in);
                    m_held  = 0;
                end else begin
                    m_owner = -1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk) begin
            check("cyc_gnt", int'(gnt_out), (m_owner < 0) ? 0 : (1 << m_owner));
            check("cyc_vld", int'(gnt_valid_out), int'(m_owner >= 0));
            if (m_owner >= 0) check("cyc_idx", int'(gnt_idx_out), m_owner);
            check("cyc_to", int'(timeout_out), int'(m_to));
            check("cyc_ptr", int'(dut.ptr), m_ptr);
            check("cyc_inv", int'(gnt_valid_out), int'(|gnt_out));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        en_in  = 1'b0;
        req_in = 4'b0000;
        tick();
        tick();
        rst = 1'b0;
        chk = 1'b1;
    endtask

    initial begin
        int order [5];
        logic [3:0] r;
        order = '{0, 1, 2, 3, 0};

        // 1: reset then single request
        do_reset();
        check("rst_gnt", int'(gnt_out), 0);
        check("rst_vld", int'(gnt_valid_out), 0);
        check("rst_idx", int'(gnt_idx_out), 0);
        check("rst_to", int'(timeout_out), 0);
        check("rst_ptr", int'(dut.ptr), 0);
        en_in  = 1'b1;
        req_in = 4'b0100;
        tick();
        check("t1_gnt", int'(gnt_out), 4);
        check("t1_idx", int'(gnt_idx_out), 2);
        check("t1_model_owner", m_owner, 2);
        tick();
        tick();
        req_in = 4'b0000;
        tick();
        check("t1_drop", int'(gnt_out), 0);
        check("t1_ptr", int'(dut.ptr), 3);

        // 2: round-robin rotation with no idle cycle between owners
        do_reset();
        en_in  = 1'b1;
        req_in = 4'b1111;
        tick();
        check("t2_first", int'(gnt_out), 1);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("t2_hold", int'(gnt_out), 1 << order[k]);
            r      = 4'b0001 << order[k];
            req_in = 4'b1111 & ~r;
            tick();
            req_in = 4'b1111;
            check("t2_next", int'(gnt_out), 1 << order[k + 1]);
            check("t2_nobubble", int'(gnt_valid_out), 1);
        end
        req_in = 4'b0000;
        tick();

        // 3: timeout between two hogs
        do_reset();
        en_in  = 1'b1;
        req_in = 4'b0011;
        tick();
        check("t3_g0", int'(gnt_out), 1);
        for (int n = 2; n <= 8; n++) begin
            tick();
            check("t3_h0", int'(gnt_out), 1);
            check("t3_to0", int'(timeout_out), 0);
        end
        tick();
        check("t3_g1", int'(gnt_out), 2);
        check("t3_pulse1", int'(timeout_out), 1);
        for (int n = 2; n <= 8; n++) begin
            tick();
            check("t3_h1", int'(gnt_out), 2);
            check("t3_to1", int'(timeout_out), 0);
        end
        tick();
        check("t3_back0", int'(gnt_out), 1);
        check("t3_pulse2", int'(timeout_out), 1);
        tick();
        check("t3_pulse_end", int'(timeout_out), 0);
        req_in = 4'b0000;
        tick();

        // 4: lone hog is re-granted without a gap
        do_reset();
        en_in  = 1'b1;
        req_in = 4'b0001;
        for (int n = 1; n <= 20; n++) begin
            tick();
            check("t4_gnt", int'(gnt_out), 1);
            check("t4_to", int'(timeout_out), int'(n == 9 || n == 17));
        end
        req_in = 4'b0000;
        tick();
        check("t4_drop", int'(gnt_out), 0);

        // 5: enable gating
        do_reset();
        en_in  = 1'b1;
        req_in = 4'b0100;
        tick();
        check("t5_g2", int'(gnt_out), 4);
        en_in  = 1'b0;
        req_in = 4'b1100;
        tick();
        check("t5_keep", int'(gnt_out), 4);
        tick();
        check("t5_keep2", int'(gnt_out), 4);
        req_in = 4'b1000;
        tick();
        check("t5_off", int'(gnt_out), 0);
        check("t5_ptr", int'(dut.ptr), 3);
        check("t5_model_ptr", m_ptr, 3);
        tick();
        tick();
        check("t5_still_off", int'(gnt_out), 0);
        en_in = 1'b1;
        tick();
        check("t5_g3", int'(gnt_out), 8);

        // 6: reset in the middle of a grant
        do_reset();
        en_in  = 1'b1;
        req_in = 4'b0010;
        tick();
        check("t6_g1", int'(gnt_out), 2);
        tick();
        tick();
        tick();
        check("t6_hcnt", int'(dut.hold_cnt), 3);
        rst = 1'b1;
        tick();
        check("t6_gnt", int'(gnt_out), 0);
        check("t6_vld", int'(gnt_valid_out), 0);
        check("t6_idx", int'(gnt_idx_out), 0);
        check("t6_to", int'(timeout_out), 0);
        check("t6_ptr", int'(dut.ptr), 0);
        rst    = 1'b0;
        req_in = 4'b1111;
        tick();
        check("t6_first", int'(gnt_out), 1);

        req_in = 4'b0000;
        en_in  = 1'b0;
        tick();
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
